// File: rtl/fp_issue_sequencer.sv
// Single-issue FP launch/writeback sequencer: IDLE -> RUN (latency count) -> WB (write-port arbitration).
// Optional macro FP_ISSUE_SEQ_DIV_EN enables FDIV (op 11); otherwise op 11 is flagged illegal and never issues.
module fp_issue_sequencer #(
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       IsFpD,
   input  logic [1:0] FpOpD,
   input  logic [4:0] RdD,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic       FlushD,
   input  logic       StallDIn,
   input  logic       RegWriteW,
   output logic       FpStartE,
   output logic [1:0] FpOpE,
   output logic       FpBusy,
   output logic       StallF,
   output logic       StallD,
   output logic       FpRegWriteW,
   output logic [4:0] FpRdW,
   output logic       FpDoneW,
   output logic       FpIllegalD
);

   localparam int AM_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
`ifdef FP_ISSUE_SEQ_DIV_EN
   localparam int   MAX_LAT = (AM_LAT > DIV_LAT) ? AM_LAT : DIV_LAT;
   localparam logic DIV_OK  = 1'b1;
`else
   localparam int   MAX_LAT = AM_LAT;
   localparam logic DIV_OK  = 1'b0;
`endif
   localparam int CW          = $clog2(MAX_LAT) + 1;
   localparam int DIV_LAT_EFF = DIV_OK ? DIV_LAT : 1;

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [4:0]    rdq_reg;
   logic [1:0]    op_reg;
   logic          start_reg;

   logic [CW-1:0] lat_tab [4];
   logic [3:0]    legal_tab;

   // Per-op load value (latency - 1) and legality, indexed directly by FpOpD.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_op
      localparam int LAT = (gi < 2) ? ADD_LAT : ((gi == 2) ? MUL_LAT : DIV_LAT_EFF);
      assign lat_tab[gi]   = CW'(LAT - 1);
      assign legal_tab[gi] = (gi != 3) ? 1'b1 : DIV_OK;
   end

   logic live, dec_valid, issue, raw, stall, wb_free;

   assign live      = ~reset;
   assign dec_valid = ~FlushD;
   assign issue     = (state_reg == IDLE) & IsFpD & dec_valid & ~StallDIn & legal_tab[FpOpD];
   assign raw       = (rdq_reg != 5'd0) &
                      ((Rs1D == rdq_reg) | (Rs2D == rdq_reg) | (RdD == rdq_reg));
   // WB blocks every valid Decode instruction so the integer pipe drains and frees the write slot.
   assign stall     = live & dec_valid &
                      (((state_reg == RUN) & (IsFpD | raw)) | (state_reg == WB));
   assign wb_free   = (state_reg == WB) & ~RegWriteW;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (issue) begin
               state_next = RUN;
               cnt_next   = lat_tab[FpOpD];
            end
         end
         RUN: begin
            if (cnt_reg == '0) state_next = WB;
            else               cnt_next   = cnt_reg - CW'(1);
         end
         WB: begin
            if (wb_free) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rdq_reg   <= '0;
         op_reg    <= '0;
         start_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         start_reg <= issue;
         if (issue) begin
            op_reg  <= FpOpD;
            rdq_reg <= RdD;
         end
      end
   end

   assign FpBusy      = live & (state_reg != IDLE);
   assign FpStartE    = live & start_reg;
   assign FpOpE       = live ? op_reg : 2'b00;
   assign FpRdW       = live ? rdq_reg : 5'd0;
   assign StallF      = stall;
   assign StallD      = stall;
   assign FpDoneW     = live & wb_free;
   assign FpRegWriteW = live & wb_free & (rdq_reg != 5'd0);
`ifdef FP_ISSUE_SEQ_DIV_EN
   assign FpIllegalD  = 1'b0;
`else
   assign FpIllegalD  = live & (state_reg == IDLE) & IsFpD & dec_valid & (FpOpD == 2'b11);
`endif

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Bench for fp_issue_sequencer: directed scenarios then random traffic, checked every cycle
// against a cycle-count model of the in-flight op (issue time + latency, write slot grant).
module tb_fp_issue_sequencer;

   localparam int A_LAT = 2;
   localparam int M_LAT = 3;
   localparam int D_LAT = 12;
`ifdef FP_ISSUE_SEQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, IsFpD, FlushD, StallDIn, RegWriteW;
   logic [1:0] FpOpD;
   logic [4:0] RdD, Rs1D, Rs2D;
   logic FpStartE, FpBusy, StallF, StallD, FpRegWriteW, FpDoneW, FpIllegalD;
   logic [1:0] FpOpE;
   logic [4:0] FpRdW;

   fp_issue_sequencer #(.ADD_LAT(A_LAT), .MUL_LAT(M_LAT), .DIV_LAT(D_LAT)) dut (
      .clk(clk), .reset(reset), .IsFpD(IsFpD), .FpOpD(FpOpD), .RdD(RdD), .Rs1D(Rs1D),
      .Rs2D(Rs2D), .FlushD(FlushD), .StallDIn(StallDIn), .RegWriteW(RegWriteW),
      .FpStartE(FpStartE), .FpOpE(FpOpE), .FpBusy(FpBusy), .StallF(StallF), .StallD(StallD),
      .FpRegWriteW(FpRegWriteW), .FpRdW(FpRdW), .FpDoneW(FpDoneW), .FpIllegalD(FpIllegalD)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: one op in flight, described by when it issued and how long it runs.
   int cyc = 0;
   bit inflight = 1'b0;
   bit issued_since_reset = 1'b0;
   int issue_t = 0;
   int lat_m = 0;
   logic [4:0] m_rd = '0;
   logic [1:0] m_op = '0;
   int last_start_cyc = -1;
   int last_wr_cyc = -1;
   int last_done_cyc = -1;

   function automatic int lat_of(input logic [1:0] op);
      if (op == 2'b10) return M_LAT;
      if (op == 2'b11) return D_LAT;
      return A_LAT;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic isfp, input logic [1:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic flush, input logic sdin, input logic regw);
      bit run_e, wb_e, haz, stall_e, grant, wr_e, start_e, ill_e;
      @(negedge clk);
      reset = rst; IsFpD = isfp; FpOpD = op; RdD = rd; Rs1D = rs1; Rs2D = rs2;
      FlushD = flush; StallDIn = sdin; RegWriteW = regw;
      #1;
      run_e   = inflight && (cyc > issue_t) && (cyc <= issue_t + lat_m);
      wb_e    = inflight && (cyc > issue_t + lat_m);
      haz     = (m_rd != 5'd0) && ((rs1 == m_rd) || (rs2 == m_rd) || (rd == m_rd));
      stall_e = !flush && ((run_e && (isfp || haz)) || wb_e);
      grant   = wb_e && !regw;
      wr_e    = grant && (m_rd != 5'd0);
      start_e = inflight && (cyc == issue_t + 1);
      ill_e   = !DIV_EN && !inflight && isfp && !flush && (op == 2'b11);
      if (rst) begin
         stall_e = 0; grant = 0; wr_e = 0; start_e = 0; ill_e = 0;
      end
      if (FpStartE === 1'b1) last_start_cyc = cyc;
      if (FpRegWriteW === 1'b1) last_wr_cyc = cyc;
      if (FpDoneW === 1'b1) last_done_cyc = cyc;
      chk("busy", FpBusy, (!rst && inflight) ? 1 : 0);
      chk("start", FpStartE, start_e);
      chk("stallf", StallF, stall_e);
      chk("stalld", StallD, stall_e);
      chk("regwrite", FpRegWriteW, wr_e);
      chk("done", FpDoneW, grant);
      chk("illegal", FpIllegalD, ill_e);
      if (rst || !issued_since_reset) begin
         chk("ope_zero", FpOpE, 0);
         chk("rdw_zero", FpRdW, 0);
      end else if (inflight) begin
         chk("ope", FpOpE, m_op);
         chk("rdw", FpRdW, m_rd);
      end
      if (rst) begin
         inflight = 0;
         issued_since_reset = 0;
      end else if (grant) begin
         inflight = 0;
         $display("txn cyc=%0d op=%0d rd=%0d issued=%0d write=%0d", cyc, m_op, m_rd, issue_t, wr_e);
      end else if (!inflight && isfp && !flush && !sdin && (op != 2'b11 || DIV_EN)) begin
         inflight = 1; issued_since_reset = 1;
         issue_t = cyc; lat_m = lat_of(op); m_rd = rd; m_op = op;
      end
      cyc++;
   endtask

   task automatic nop(input int n, input logic regw);
      for (int i = 0; i < n; i++) step(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, regw);
   endtask

   initial begin
      int c0;
      logic [1:0] dop;
      reset = 1; IsFpD = 0; FpOpD = 0; RdD = 0; Rs1D = 0; Rs2D = 0;
      FlushD = 0; StallDIn = 0; RegWriteW = 0;

      for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      nop(2, 0);

      // FADD rd=5, no contention
      c0 = cyc;
      step(0, 1, 2'b00, 5'd5, 5'd1, 5'd2, 0, 0, 0);
      nop(5, 0);
      chk("fadd_start_cyc", last_start_cyc, c0 + 1);
      chk("fadd_wr_cyc", last_wr_cyc, c0 + A_LAT + 1);

      // FMUL with two cycles of integer writeback contention in WB
      c0 = cyc;
      step(0, 1, 2'b10, 5'd3, 5'd0, 5'd0, 0, 0, 0);
      nop(M_LAT, 0);
      nop(2, 1);
      nop(3, 0);
      chk("fmul_wr_delayed", last_wr_cyc, c0 + M_LAT + 3);

      // Long op then a dependent ADD held in Decode
      dop = DIV_EN ? 2'b11 : 2'b10;
      c0 = cyc;
      step(0, 1, dop, 5'd7, 5'd0, 5'd0, 0, 0, 0);
      for (int i = 0; i < lat_of(dop) + 3; i++) step(0, 1, 2'b00, 5'd8, 5'd7, 5'd0, 0, 0, 0);
      chk("dep_wr_cyc", last_wr_cyc, c0 + lat_of(dop) + 1);
      chk("dep_issue_cyc", last_start_cyc, c0 + lat_of(dop) + 3);
      nop(6, 0);

      // Flushed, StallDIn-blocked and illegal ops never issue
      c0 = last_start_cyc;
      step(0, 1, 2'b00, 5'd4, 5'd0, 5'd0, 1, 0, 0);
      step(0, 1, 2'b01, 5'd4, 5'd0, 5'd0, 0, 1, 0);
      step(0, 1, 2'b11, 5'd4, 5'd0, 5'd0, 0, 0, 0);
      if (DIV_EN) nop(D_LAT + 3, 0);
      else begin
         nop(2, 0);
         chk("no_issue_blocked", last_start_cyc, c0);
      end

      // Reset on the third RUN cycle discards the op
      last_wr_cyc = -1;
      step(0, 1, 2'b10, 5'd9, 5'd0, 5'd0, 0, 0, 0);
      nop(2, 0);
      step(1, 0, 2'b00, 5'd0, 5'd9, 5'd0, 0, 0, 0);
      nop(M_LAT + 3, 0);
      chk("no_wr_after_reset", last_wr_cyc, -1);
      c0 = cyc;
      step(0, 1, 2'b00, 5'd6, 5'd0, 5'd0, 0, 0, 0);
      nop(5, 0);
      chk("fadd_after_reset_wr", last_wr_cyc, c0 + A_LAT + 1);

      // FMUL rd=0: completion pulse without write, no stall on x0 readers
      last_wr_cyc = -1;
      c0 = cyc;
      step(0, 1, 2'b10, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      nop(6, 0);
      chk("x0_done_cyc", last_done_cyc, c0 + M_LAT + 1);
      chk("x0_no_write", last_wr_cyc, -1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 1) == 1),
              2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 2) == 0));
      end
      nop(D_LAT + 4, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_issue_sequencer.md
# fp_issue_sequencer

Multi-cycle floating-point issue and writeback sequencer for the 5-stage pipelined core. It takes FP instructions flagged by the decode-stage controller (IsFpD/FpOpD), launches one operation at a time into the iterative FP datapath, and counts its per-op latency. It stalls Fetch/Decode on structural and RAW hazards against the in-flight destination, then arbitrates the shared register-file write port against the integer writeback stream.

## Interface
Parameters:
- ADD_LAT, default 2: execute cycles for FADD/FSUB (FpOp 00/01); must be ≥1
- MUL_LAT, default 3: execute cycles for FMUL (FpOp 10); must be ≥1
- DIV_LAT, default 12: execute cycles for FDIV (FpOp 11); must be ≥1
- Counter width is $clog2(max latency)+1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- IsFpD  in  1  instruction in Decode is an FP op
- FpOpD  in  2  00 add, 01 sub, 10 mul, 11 div
- RdD, Rs1D, Rs2D  in  5 each  Decode register fields
- FlushD  in  1  Decode instruction is wrong-path; never issue it
- StallDIn  in  1  integer hazard unit is stalling Decode; never issue
- RegWriteW  in  1  integer pipeline is writing the register file this cycle
- FpStartE  out  1  one-cycle launch pulse to FP datapath
- FpOpE  out  2  latched op, stable from FpStartE until return to IDLE
- FpBusy  out  1  state ≠ IDLE
- StallF, StallD  out  1 each  freeze Fetch/Decode (combinational)
- FpRegWriteW  out  1  FP result write enable; also the writeback mux select
- FpRdW  out  5  FP destination register
- FpDoneW  out  1  one-cycle completion pulse (also fires for rd = x0)
- FpIllegalD  out  1  op rejected (see Configuration)

## Operation
- FSM: IDLE, RUN, WB.
- IDLE: issue when IsFpD & ~FlushD & ~StallDIn & op legal.
  - Next: RUN, FpStartE=1, FpOpE←FpOpD, rdq←RdD, cnt←LAT(op)−1.
- RUN: cnt decrements each cycle; when cnt==0, go to WB.
- WB:
  - If RegWriteW=0: assert FpDoneW, and FpRegWriteW iff rdq≠0, for exactly this cycle; next state is IDLE.
  - If RegWriteW=1: integer writeback wins; remain in WB.
- Hazard stall (StallF=StallD=1):
  - RUN with a Decode instruction where IsFpD=1 (structural), or Rs1D==rdq or Rs2D==rdq with rdq≠0, or RdD==rdq with rdq≠0 (WAW).
  - WB: any valid Decode instruction. This drains the integer pipe so the write slot is granted within 3 cycles.
- FlushD overrides: a flushed Decode instruction never causes issue or stall.
- A stalled FP instruction issues on the first IDLE cycle in which the issue condition holds. There is no back-to-back issue from WB.
- reset (any state, including mid-RUN/WB): state←IDLE, cnt←0, rdq←0. The in-flight op is discarded with no write. All outputs are 0.

## Timing
- Issue condition true in cycle T:
  - FpStartE high in T+1 only.
  - RUN spans T+1..T+LAT.
  - WB is entered at T+LAT+1; with no contention, FpRegWriteW is high in T+LAT+1.
- Each WB cycle that sees RegWriteW=1 adds one cycle of latency.
- Stall outputs are combinational from state and Decode inputs in the same cycle; no registered delay.
- FpOpE and FpRdW hold from T+1 until IDLE is re-entered.

## Configuration
- Macro FP_ISSUE_SEQ_DIV_EN.
- Defined: op 11 issues with DIV_LAT.
- Undefined:
  - op 11 is illegal. In IDLE with IsFpD & ~FlushD & FpOpD==11, FpIllegalD=1 combinationally and nothing issues (NOP).
  - DIV_LAT is ignored for counter sizing.
  - FpIllegalD is tied 0 when the macro is defined.

## Test plan
- FADD rd=5 issued at cycle 10, no contention:
  - FpStartE=1 at 11
  - FpBusy=1 during 11–13
  - FpRegWriteW=1, FpRdW=5, FpDoneW=1 at 13
  - FpBusy=0 at 14
- FDIV rd=7 (macro defined), then a dependent ADD with Rs1D=7 held in Decode:
  - StallD=1 during cycles T+1..T+13
  - Write occurs at T+13
  - The ADD leaves Decode at T+14
- FMUL in WB while RegWriteW=1 for 2 consecutive cycles:
  - FpRegWriteW is delayed 2 cycles and never coincides with RegWriteW
  - StallD=1 throughout WB
- IsFpD with FlushD=1, then IsFpD with StallDIn=1: no FpStartE, FpBusy stays 0. FpOp=11 with the macro undefined: FpIllegalD=1, no issue.
- reset asserted on the 3rd RUN cycle of an FDIV:
  - Next cycle: FpBusy=0, StallD=0, and no FpRegWriteW ever occurs
  - A new FADD issued next completes normally
- FMUL with rd=0: FpDoneW=1 at T+4 with FpRegWriteW=0, and no stall on Rs1D=0.
